// File: rtl/uart_stream_ctrl_if.sv
// Purpose: UART-side bundle between uart_stream_ctrl and the uart_rx/uart_tx pair.
// Ports  : rx_data/rx_valid/rx_break/rx_en on the receive side,
//          tx_data/tx_en/tx_busy on the transmit side; master = controller.
interface uart_stream_ctrl_if #(
  parameter int WIDTH = 8
) ();
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             rx_break;
  logic             rx_en;
  logic [WIDTH-1:0] tx_data;
  logic             tx_en;
  logic             tx_busy;

  modport master (
    input  rx_data, rx_valid, rx_break, tx_busy,
    output rx_en, tx_data, tx_en
  );

  modport slave (
    output rx_data, rx_valid, rx_break, tx_busy,
    input  rx_en, tx_data, tx_en
  );
endinterface

// File: rtl/uart_stream_ctrl.sv
// Purpose: buffers uart_rx words in a FIFO and feeds uart_tx one word at a time
//          (echo / line / drop modes), with BREAK flush and overflow reporting.
// Ports  : i_clk, i_rst (sync, active high), i_mode, i_clr_ovf, io_uart (master),
//          o_level, o_empty, o_full, o_overflow. rx_valid->tx_en latency is 2 cycles.
module uart_stream_ctrl #(
  parameter int               WIDTH          = 8,
  parameter int               DEPTH          = 16,
  parameter int               RX_STOP_MARGIN = 2,
  parameter logic [WIDTH-1:0] TERM_CHAR      = WIDTH'(8'h0D),
  parameter int               TX_ACK_TIMEOUT = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [1:0]             i_mode,
  input  logic                   i_clr_ovf,
  uart_stream_ctrl_if.master     io_uart,
  output logic [$clog2(DEPTH):0] o_level,
  output logic                   o_empty,
  output logic                   o_full,
  output logic                   o_overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = $clog2(TX_ACK_TIMEOUT) + 1;
  localparam logic [LW-1:0] DEPTH_L  = LW'(DEPTH);
  localparam logic [LW-1:0] STOP_L   = LW'(DEPTH - RX_STOP_MARGIN);
  localparam logic [TW-1:0] TMO_LAST = TW'(TX_ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT_HI, S_WAIT_LO} state_t;
  state_t r_state, w_state_next;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [LW-1:0]    r_level, w_level_next;
  logic [LW-1:0]    r_lines_pending, w_lines_next;
  logic             r_overflow, r_force_drain, r_rx_en;
  logic             r_tx_en, w_tx_en_next;
  logic [WIDTH-1:0] r_tx_data, w_tx_data_next, w_head;
  logic [TW-1:0]    r_timer, w_timer_next;
  logic             w_full, w_empty, w_eligible;
  logic             w_push_req, w_push, w_drop, w_pop, w_push_term, w_pop_term;

  assign w_full  = (r_level == DEPTH_L);
  assign w_empty = (r_level == '0);
  assign w_head  = r_mem[r_rd_ptr];

  // Line mode holds words until a full line is queued, unless the FIFO filled
  // up without a terminator (force_drain), which would otherwise deadlock.
  always_comb begin
    w_eligible = !w_empty;
    if (i_mode == 2'd1) begin
      w_eligible = !w_empty && ((r_lines_pending != '0) || r_force_drain);
    end
  end

  // No launch in a BREAK cycle: the queued words are being discarded.
  assign w_pop       = (r_state == S_IDLE) && w_eligible && !io_uart.rx_break;
  assign w_push_req  = io_uart.rx_valid && (i_mode != 2'd2);
  // A simultaneous pop frees a slot, so a full FIFO still accepts the word.
  assign w_push      = w_push_req && !io_uart.rx_break && (!w_full || w_pop);
  assign w_drop      = w_push_req && !io_uart.rx_break && w_full && !w_pop;
  assign w_push_term = w_push && (io_uart.rx_data == TERM_CHAR);
  assign w_pop_term  = w_pop && (w_head == TERM_CHAR);

  always_comb begin
    w_level_next = r_level;
    w_lines_next = r_lines_pending;
    if (io_uart.rx_break) begin
      w_level_next = '0;
      w_lines_next = '0;
    end else begin
      w_level_next = r_level + LW'(w_push) - LW'(w_pop);
      w_lines_next = r_lines_pending + LW'(w_push_term) - LW'(w_pop_term);
    end
  end

  // TX handshake: next state and registered launch outputs.
  always_comb begin
    w_state_next   = r_state;
    w_tx_en_next   = 1'b0;
    w_tx_data_next = r_tx_data;
    w_timer_next   = r_timer;
    case (r_state)
      S_IDLE: begin
        if (w_pop) begin
          w_tx_en_next   = 1'b1;
          w_tx_data_next = w_head;
          w_state_next   = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        w_timer_next = '0;
        w_state_next = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        // A uart_tx that never acknowledges must not stall the stream.
        if (io_uart.tx_busy) begin
          w_state_next = S_WAIT_LO;
        end else if (r_timer == TMO_LAST) begin
          w_state_next = S_IDLE;
        end else begin
          w_timer_next = r_timer + TW'(1);
        end
      end
      S_WAIT_LO: begin
        if (!io_uart.tx_busy) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_tx_en   <= 1'b0;
      r_tx_data <= '0;
      r_timer   <= '0;
    end else begin
      r_state   <= w_state_next;
      r_tx_en   <= w_tx_en_next;
      r_tx_data <= w_tx_data_next;
      r_timer   <= w_timer_next;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= io_uart.rx_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_level         <= '0;
      r_lines_pending <= '0;
      r_force_drain   <= 1'b0;
      r_overflow      <= 1'b0;
      r_rx_en         <= 1'b1;
    end else begin
      if (io_uart.rx_break) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_level         <= w_level_next;
      r_lines_pending <= w_lines_next;
      if (io_uart.rx_break) begin
        r_force_drain <= 1'b0;
      end else if ((i_mode == 2'd1) && w_full && (r_lines_pending == '0)) begin
        r_force_drain <= 1'b1;
      end else if (w_empty) begin
        r_force_drain <= 1'b0;
      end
      // Set has priority over clear so a coincident drop is never lost.
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (i_clr_ovf) begin
        r_overflow <= 1'b0;
      end
      r_rx_en <= (w_level_next < STOP_L);
    end
  end

  assign io_uart.rx_en   = r_rx_en;
  assign io_uart.tx_en   = r_tx_en;
  assign io_uart.tx_data = r_tx_data;
  assign o_level         = r_level;
  assign o_empty         = w_empty;
  assign o_full          = w_full;
  assign o_overflow      = r_overflow;
endmodule

// File: tb/tb_uart_stream_ctrl.sv
// Purpose: directed bench for uart_stream_ctrl (DEPTH=16, WIDTH=8, timeout 4).
// Ports  : drives the interface as the UART pair, with a uart_tx busy model
//          that raises busy the cycle after tx_en for busy_len cycles.
module tb_uart_stream_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] mode = 2'd0;
  logic       clr_ovf = 1'b0;
  logic [4:0] level;
  logic       empty, full, overflow;

  int n_cmp = 0;
  int n_bad = 0;

  int   busy_len = 20;
  int   busy_cnt = 0;
  logic busy_force_en = 1'b0;
  logic busy_force_val = 1'b0;

  uart_stream_ctrl_if #(.WIDTH(8)) bus ();

  uart_stream_ctrl dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_mode     (mode),
    .i_clr_ovf  (clr_ovf),
    .io_uart    (bus),
    .o_level    (level),
    .o_empty    (empty),
    .o_full     (full),
    .o_overflow (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.tx_en === 1'b1) busy_cnt <= busy_len;
    else if (busy_cnt > 0)  busy_cnt <= busy_cnt - 1;
  end
  assign bus.tx_busy = busy_force_en ? busy_force_val : (busy_cnt > 0);

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_break = 1'b0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Waits for the next tx_en pulse; returns ticks waited and leaves the bench one cycle past it.
  task automatic wait_tx(input int max, output logic got, output logic [7:0] d, output int n);
    got = 1'b0;
    d = 8'h00;
    n = 0;
    while (!got && n < max) begin
      if (bus.tx_en === 1'b1) begin
        got = 1'b1;
        d = bus.tx_data;
      end else begin
        tick();
        n++;
      end
    end
    if (got) tick();
  endtask

  task automatic count_tx(input int cycles, output int c);
    c = 0;
    repeat (cycles) begin
      if (bus.tx_en === 1'b1) c++;
      tick();
    end
  endtask

  task automatic test_reset();
    tick();
    n_cmp++; if (level !== 5'd0)       begin n_bad++; $display("FAIL reset_level: got %0d want 0", level); end
    n_cmp++; if (empty !== 1'b1)       begin n_bad++; $display("FAIL reset_empty: got %b want 1", empty); end
    n_cmp++; if (full !== 1'b0)        begin n_bad++; $display("FAIL reset_full: got %b want 0", full); end
    n_cmp++; if (overflow !== 1'b0)    begin n_bad++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    n_cmp++; if (bus.tx_en !== 1'b0)   begin n_bad++; $display("FAIL reset_tx_en: got %b want 0", bus.tx_en); end
    n_cmp++; if (bus.tx_data !== 8'h0) begin n_bad++; $display("FAIL reset_tx_data: got %h want 00", bus.tx_data); end
    n_cmp++; if (bus.rx_en !== 1'b1)   begin n_bad++; $display("FAIL reset_rx_en: got %b want 1", bus.rx_en); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_timing();
    do_reset();
    mode = 2'd3;
    busy_len = 2;
    bus.rx_data = 8'h5A; bus.rx_valid = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
    n_cmp++; if (level !== 5'd1)       begin n_bad++; $display("FAIL timing_level_c1: got %0d want 1", level); end
    tick();
    n_cmp++; if (bus.tx_en !== 1'b1)   begin n_bad++; $display("FAIL timing_tx_en_c2: got %b want 1", bus.tx_en); end
    n_cmp++; if (level !== 5'd0)       begin n_bad++; $display("FAIL timing_level_c2: got %0d want 0", level); end
    n_cmp++; if (bus.tx_data !== 8'h5A) begin n_bad++; $display("FAIL timing_tx_data: got %h want 5a", bus.tx_data); end
    tick();
    n_cmp++; if (bus.tx_en !== 1'b0)   begin n_bad++; $display("FAIL timing_tx_en_width: got %b want 0", bus.tx_en); end
    n_cmp++; if (bus.tx_data !== 8'h5A) begin n_bad++; $display("FAIL timing_tx_data_hold: got %h want 5a", bus.tx_data); end
    repeat (8) tick();
  endtask

  task automatic test_echo();
    logic got; logic [7:0] d; int n;
    do_reset();
    mode = 2'd0;
    busy_len = 20;
    bus.rx_data = 8'h41; bus.rx_valid = 1'b1;
    tick();
    n_cmp++; if (level !== 5'd1)        begin n_bad++; $display("FAIL echo_level_c1: got %0d want 1", level); end
    bus.rx_data = 8'h42;
    tick();
    bus.rx_valid = 1'b0;
    n_cmp++; if (bus.tx_en !== 1'b1)    begin n_bad++; $display("FAIL echo_tx_en_c2: got %b want 1", bus.tx_en); end
    n_cmp++; if (bus.tx_data !== 8'h41) begin n_bad++; $display("FAIL echo_first_data: got %h want 41", bus.tx_data); end
    n_cmp++; if (level !== 5'd1)        begin n_bad++; $display("FAIL echo_level_c2: got %0d want 1", level); end
    tick();
    n_cmp++; if (bus.tx_en !== 1'b0)    begin n_bad++; $display("FAIL echo_tx_en_width: got %b want 0", bus.tx_en); end
    wait_tx(60, got, d, n);
    n_cmp++; if (got !== 1'b1)          begin n_bad++; $display("FAIL echo_second_launch: got %b want 1", got); end
    // busy high cycles 3..22, falls in 23, next tx_en two cycles later in 25
    n_cmp++; if (n !== 22)              begin n_bad++; $display("FAIL echo_spacing: got %0d want 22", n); end
    n_cmp++; if (d !== 8'h42)           begin n_bad++; $display("FAIL echo_second_data: got %h want 42", d); end
    repeat (30) tick();
    n_cmp++; if (level !== 5'd0)        begin n_bad++; $display("FAIL echo_level_end: got %0d want 0", level); end
    n_cmp++; if (empty !== 1'b1)        begin n_bad++; $display("FAIL echo_empty_end: got %b want 1", empty); end
  endtask

  task automatic test_line();
    logic got; logic [7:0] d; int n; int c;
    logic [7:0] exp_seq [3];
    exp_seq[0] = 8'h41; exp_seq[1] = 8'h42; exp_seq[2] = 8'h0D;
    do_reset();
    mode = 2'd1;
    busy_len = 2;
    bus.rx_valid = 1'b1;
    bus.rx_data = 8'h41; tick();
    bus.rx_data = 8'h42; tick();
    bus.rx_valid = 1'b0;
    count_tx(6, c);
    n_cmp++; if (c !== 0)               begin n_bad++; $display("FAIL line_held: got %0d launches want 0", c); end
    n_cmp++; if (level !== 5'd2)        begin n_bad++; $display("FAIL line_level_held: got %0d want 2", level); end
    bus.rx_data = 8'h0D; bus.rx_valid = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wait_tx(20, got, d, n);
      n_cmp++; if (got !== 1'b1 || d !== exp_seq[k]) begin
        n_bad++; $display("FAIL line_word%0d: got %h (seen %b) want %h", k, d, got, exp_seq[k]);
      end
    end
    repeat (8) tick();
    n_cmp++; if (dut.r_lines_pending !== 5'd0) begin n_bad++; $display("FAIL line_lines_pending: got %0d want 0", dut.r_lines_pending); end
    n_cmp++; if (level !== 5'd0)        begin n_bad++; $display("FAIL line_level_end: got %0d want 0", level); end
  endtask

  task automatic test_force_drain();
    logic got; logic [7:0] d; int n; int c;
    logic [7:0] e;
    do_reset();
    mode = 2'd1;
    busy_len = 2;
    c = 0;
    for (int k = 0; k < 16; k++) begin
      bus.rx_data = 8'(8'h30 + k); bus.rx_valid = 1'b1;
      if (bus.tx_en === 1'b1) c++;
      tick();
    end
    bus.rx_valid = 1'b0;
    n_cmp++; if (c !== 0)               begin n_bad++; $display("FAIL drain_no_early_launch: got %0d want 0", c); end
    n_cmp++; if (full !== 1'b1)         begin n_bad++; $display("FAIL drain_full: got %b want 1", full); end
    for (int k = 0; k < 16; k++) begin
      e = 8'(8'h30 + k);
      wait_tx(20, got, d, n);
      n_cmp++; if (got !== 1'b1 || d !== e) begin
        n_bad++; $display("FAIL drain_word%0d: got %h (seen %b) want %h", k, d, got, e);
      end
    end
    repeat (10) tick();
    n_cmp++; if (level !== 5'd0)        begin n_bad++; $display("FAIL drain_level_end: got %0d want 0", level); end
    n_cmp++; if (dut.r_force_drain !== 1'b0) begin n_bad++; $display("FAIL drain_flag_clear: got %b want 0", dut.r_force_drain); end
    bus.rx_data = 8'h55; bus.rx_valid = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
    count_tx(15, c);
    n_cmp++; if (c !== 0)               begin n_bad++; $display("FAIL drain_stops: got %0d launches want 0", c); end
    n_cmp++; if (level !== 5'd1)        begin n_bad++; $display("FAIL drain_level_held: got %0d want 1", level); end
  endtask

  task automatic test_overflow();
    logic got; logic [7:0] d; int n;
    logic [4:0] exp_lvl;
    logic [7:0] e;
    do_reset();
    mode = 2'd0;
    busy_force_en = 1'b1; busy_force_val = 1'b1;
    bus.rx_data = 8'hAA; bus.rx_valid = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
    wait_tx(10, got, d, n);
    n_cmp++; if (got !== 1'b1 || d !== 8'hAA) begin n_bad++; $display("FAIL ovf_preload: got %h (seen %b) want aa", d, got); end
    repeat (2) tick();
    for (int i = 1; i <= 17; i++) begin
      bus.rx_data = 8'(8'h60 + i - 1); bus.rx_valid = 1'b1;
      tick();
      exp_lvl = (i > 16) ? 5'd16 : 5'(i);
      n_cmp++; if (level !== exp_lvl) begin n_bad++; $display("FAIL ovf_level_push%0d: got %0d want %0d", i, level, exp_lvl); end
      n_cmp++; if (bus.rx_en !== (exp_lvl < 5'd14)) begin n_bad++; $display("FAIL ovf_rx_en_push%0d: got %b want %b", i, bus.rx_en, exp_lvl < 5'd14); end
      n_cmp++; if (overflow !== (i == 17)) begin n_bad++; $display("FAIL ovf_flag_push%0d: got %b want %b", i, overflow, i == 17); end
    end
    bus.rx_valid = 1'b0;
    n_cmp++; if (full !== 1'b1)         begin n_bad++; $display("FAIL ovf_full: got %b want 1", full); end
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    n_cmp++; if (overflow !== 1'b0)     begin n_bad++; $display("FAIL ovf_clear: got %b want 0", overflow); end
    bus.rx_data = 8'h99; bus.rx_valid = 1'b1; clr_ovf = 1'b1;
    tick();
    bus.rx_valid = 1'b0; clr_ovf = 1'b0;
    n_cmp++; if (overflow !== 1'b1)     begin n_bad++; $display("FAIL ovf_set_beats_clear: got %b want 1", overflow); end
    n_cmp++; if (level !== 5'd16)       begin n_bad++; $display("FAIL ovf_level_after_drop: got %0d want 16", level); end
    busy_len = 2;
    busy_force_en = 1'b0;
    for (int k = 0; k < 16; k++) begin
      e = 8'(8'h60 + k);
      wait_tx(20, got, d, n);
      n_cmp++; if (got !== 1'b1 || d !== e) begin
        n_bad++; $display("FAIL ovf_drain_word%0d: got %h (seen %b) want %h", k, d, got, e);
      end
    end
    repeat (8) tick();
    n_cmp++; if (level !== 5'd0)        begin n_bad++; $display("FAIL ovf_level_end: got %0d want 0", level); end
    n_cmp++; if (bus.rx_en !== 1'b1)    begin n_bad++; $display("FAIL ovf_rx_en_end: got %b want 1", bus.rx_en); end
  endtask

  task automatic test_drop();
    logic got; logic [7:0] d; int n;
    do_reset();
    mode = 2'd0;
    busy_force_en = 1'b1; busy_force_val = 1'b1;
    bus.rx_valid = 1'b1;
    bus.rx_data = 8'hB0; tick();
    bus.rx_data = 8'hB1; tick();
    bus.rx_data = 8'hB2; tick();
    bus.rx_valid = 1'b0;
    repeat (3) tick();
    n_cmp++; if (level !== 5'd2)        begin n_bad++; $display("FAIL drop_queued: got %0d want 2", level); end
    mode = 2'd2;
    bus.rx_data = 8'hB3; bus.rx_valid = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
    tick();
    n_cmp++; if (level !== 5'd2)        begin n_bad++; $display("FAIL drop_discard: got %0d want 2", level); end
    n_cmp++; if (overflow !== 1'b0)     begin n_bad++; $display("FAIL drop_no_overflow: got %b want 0", overflow); end
    busy_len = 2;
    busy_force_en = 1'b0;
    wait_tx(20, got, d, n);
    n_cmp++; if (got !== 1'b1 || d !== 8'hB1) begin n_bad++; $display("FAIL drop_drain0: got %h (seen %b) want b1", d, got); end
    wait_tx(20, got, d, n);
    n_cmp++; if (got !== 1'b1 || d !== 8'hB2) begin n_bad++; $display("FAIL drop_drain1: got %h (seen %b) want b2", d, got); end
    repeat (8) tick();
    n_cmp++; if (level !== 5'd0)        begin n_bad++; $display("FAIL drop_level_end: got %0d want 0", level); end
    mode = 2'd0;
  endtask

  task automatic test_timeout();
    logic got; logic [7:0] d; int n;
    do_reset();
    mode = 2'd0;
    busy_force_en = 1'b1; busy_force_val = 1'b0;
    bus.rx_valid = 1'b1;
    bus.rx_data = 8'h81; tick();
    bus.rx_data = 8'h82; tick();
    bus.rx_valid = 1'b0;
    n_cmp++; if (bus.tx_en !== 1'b1 || bus.tx_data !== 8'h81) begin
      n_bad++; $display("FAIL tmo_first: got en=%b data=%h want en=1 data=81", bus.tx_en, bus.tx_data);
    end
    tick();
    wait_tx(20, got, d, n);
    // WAIT_HI for 4 cycles (3..6), IDLE in 7, next launch in 8
    n_cmp++; if (got !== 1'b1 || n !== 5) begin n_bad++; $display("FAIL tmo_relaunch: got wait %0d (seen %b) want 5", n, got); end
    n_cmp++; if (d !== 8'h82)           begin n_bad++; $display("FAIL tmo_second_data: got %h want 82", d); end
    repeat (10) tick();
    busy_force_en = 1'b0;
  endtask

  task automatic queue_six(input logic [7:0] base);
    do_reset();
    mode = 2'd0;
    busy_len = 10;
    for (int k = 0; k < 6; k++) begin
      bus.rx_data = 8'(base + 8'(k)); bus.rx_valid = 1'b1;
      tick();
    end
    bus.rx_valid = 1'b0;
  endtask

  task automatic test_break();
    logic got; logic [7:0] d; int n; int c;
    queue_six(8'h70);
    n_cmp++; if (level !== 5'd5)        begin n_bad++; $display("FAIL brk_queued: got %0d want 5", level); end
    bus.rx_break = 1'b1; bus.rx_data = 8'hEE; bus.rx_valid = 1'b1;
    tick();
    bus.rx_break = 1'b0; bus.rx_valid = 1'b0;
    n_cmp++; if (level !== 5'd0)        begin n_bad++; $display("FAIL brk_level: got %0d want 0", level); end
    n_cmp++; if (empty !== 1'b1)        begin n_bad++; $display("FAIL brk_empty: got %b want 1", empty); end
    count_tx(20, c);
    n_cmp++; if (c !== 0)               begin n_bad++; $display("FAIL brk_no_launch: got %0d launches want 0", c); end
    n_cmp++; if (bus.tx_data !== 8'h70) begin n_bad++; $display("FAIL brk_inflight_data: got %h want 70", bus.tx_data); end
    bus.rx_data = 8'h7F; bus.rx_valid = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
    wait_tx(10, got, d, n);
    n_cmp++; if (got !== 1'b1 || d !== 8'h7F) begin n_bad++; $display("FAIL brk_resume: got %h (seen %b) want 7f", d, got); end
    repeat (15) tick();
  endtask

  task automatic test_rst_mid();
    int c;
    queue_six(8'h90);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if (level !== 5'd0)       begin n_bad++; $display("FAIL rstmid_level: got %0d want 0", level); end
    n_cmp++; if (empty !== 1'b1 || full !== 1'b0) begin n_bad++; $display("FAIL rstmid_status: got empty=%b full=%b want 1/0", empty, full); end
    n_cmp++; if (overflow !== 1'b0)    begin n_bad++; $display("FAIL rstmid_overflow: got %b want 0", overflow); end
    n_cmp++; if (bus.tx_en !== 1'b0)   begin n_bad++; $display("FAIL rstmid_tx_en: got %b want 0", bus.tx_en); end
    n_cmp++; if (bus.tx_data !== 8'h0) begin n_bad++; $display("FAIL rstmid_tx_data: got %h want 00", bus.tx_data); end
    n_cmp++; if (bus.rx_en !== 1'b1)   begin n_bad++; $display("FAIL rstmid_rx_en: got %b want 1", bus.rx_en); end
    count_tx(20, c);
    n_cmp++; if (c !== 0)              begin n_bad++; $display("FAIL rstmid_no_launch: got %0d launches want 0", c); end
  endtask

  initial begin
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    bus.rx_break = 1'b0;
    @(negedge clk);
    test_reset();
    test_timing();
    test_echo();
    test_line();
    test_force_drain();
    test_overflow();
    test_drop();
    test_timeout();
    test_break();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
